// File: rtl/load_seq_ctrl_if.sv
// Parameter-word stream into the load sequencer and the write bus it drives
// towards the conv-unit weight and bias memories.
interface load_seq_ctrl_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 15,
  parameter int NUMBER_OF_UNITS = 2
);
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      riscv_data;
  logic [ADDRESS_BITS-1:0]    riscv_address;
  logic [NUMBER_OF_UNITS-1:0] wm_enable_write;
  logic [NUMBER_OF_UNITS-1:0] bm_enable_write;

  // Parameter source side: offers words, observes the memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, riscv_data, riscv_address, wm_enable_write, bm_enable_write
  );
endinterface

// File: rtl/load_seq_ctrl.sv
// Streams parameter words into each conv unit's weight memory then bias
// memory, unit by unit, and kicks off the first layer once all are loaded.
module load_seq_ctrl #(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 15,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 16,
  parameter int NUMBER_OF_UNITS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              abort,
  load_seq_ctrl_if.slave    bus,
  output logic              busy,
  output logic              load_done,
  output logic              start_to_next
);

  localparam int WM_WORDS  = KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS * 3;
  localparam int BM_WORDS  = NUMBER_OF_FILTERS;
  localparam int MAX_WORDS = (WM_WORDS > BM_WORDS) ? WM_WORDS : BM_WORDS;
  localparam int WORD_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int UNIT_W    = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;

  localparam logic [WORD_W-1:0] WM_LAST   = WORD_W'(WM_WORDS - 1);
  localparam logic [WORD_W-1:0] BM_LAST   = WORD_W'(BM_WORDS - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(NUMBER_OF_UNITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_WM = 2'd1,
    LOAD_BM = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [UNIT_W-1:0]          unit_cnt_q, unit_cnt_d;
  logic [WORD_W-1:0]          word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [ADDRESS_BITS-1:0]    addr_q, addr_d;
  logic [NUMBER_OF_UNITS-1:0] wm_en_q, wm_en_d;
  logic [NUMBER_OF_UNITS-1:0] bm_en_q, bm_en_d;
  logic                       start_q, start_d;

  logic                       loading;
  logic                       accept;
  logic [NUMBER_OF_UNITS-1:0] unit_onehot;

  assign loading     = (state_q == LOAD_WM) || (state_q == LOAD_BM);
  // Abort closes the handshake in the same cycle so an offered beat is lost.
  assign bus.in_ready = loading && !abort;
  assign accept       = bus.in_ready && bus.in_valid;
  assign unit_onehot  = NUMBER_OF_UNITS'(1) << unit_cnt_q;

  // NOTE: every signal gets its default first so no path through the
  // case/if tree leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wm_en_d    = '0;
    bm_en_d    = '0;
    start_d    = 1'b0;

    if (accept) begin
      data_d = bus.in_data;
      addr_d = ADDRESS_BITS'(word_cnt_q);
    end

    if (abort) begin
      state_d    = IDLE;
      unit_cnt_d = '0;
      word_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (load_start) begin
            state_d    = LOAD_WM;
            unit_cnt_d = '0;
            word_cnt_d = '0;
          end
        end

        LOAD_WM: begin
          if (accept) begin
            wm_en_d = unit_onehot;
            if (word_cnt_q == WM_LAST) begin
              state_d    = LOAD_BM;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WORD_W'(1);
            end
          end
        end

        LOAD_BM: begin
          if (accept) begin
            bm_en_d = unit_onehot;
            if (word_cnt_q == BM_LAST) begin
              word_cnt_d = '0;
              if (unit_cnt_q != UNIT_LAST) begin
                state_d    = LOAD_WM;
                unit_cnt_d = unit_cnt_q + UNIT_W'(1);
              end else begin
                state_d = DONE;
                start_d = 1'b1;
              end
            end else begin
              word_cnt_d = word_cnt_q + WORD_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      unit_cnt_q <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wm_en_q    <= '0;
      bm_en_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wm_en_q    <= wm_en_d;
      bm_en_q    <= bm_en_d;
      start_q    <= start_d;
    end
  end

  assign bus.riscv_data      = data_q;
  assign bus.riscv_address   = addr_q;
  assign bus.wm_enable_write = wm_en_q;
  assign bus.bm_enable_write = bm_en_q;
  assign busy                = loading;
  assign load_done           = (state_q == DONE);
  // Registered on the LOAD_BM -> DONE transition, so high only on DONE entry.
  assign start_to_next       = start_q;

  a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({wm_en_q, bm_en_q}));

  a_strobe_needs_beat: assert property (@(posedge clk) disable iff (!reset)
    (|{wm_en_q, bm_en_q}) |-> $past(accept));

  a_start_in_done: assert property (@(posedge clk) disable iff (!reset)
    start_q |-> (state_q == DONE));

  a_unit_range: assert property (@(posedge clk) disable iff (!reset)
    unit_cnt_q <= UNIT_LAST);

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Scoreboard bench for load_seq_ctrl with a 2-unit, 6+2 word configuration.
module tb_load_seq_ctrl;

  localparam int DW    = 32;
  localparam int AB    = 15;
  localparam int KS    = 1;
  localparam int NF    = 2;
  localparam int NU    = 2;
  localparam int WM    = KS * KS * NF * 3;
  localparam int BM    = NF;
  localparam int PER   = WM + BM;
  localparam int TOTAL = NU * PER;

  typedef struct {
    int            cyc;
    logic [NU-1:0] wm;
    logic [NU-1:0] bm;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic load_start;
  logic abort;
  logic busy;
  logic load_done;
  logic start_to_next;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  stn_seen = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  load_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .NUMBER_OF_UNITS(NU)) bus ();

  load_seq_ctrl #(
    .DATA_WIDTH       (DW),
    .ADDRESS_BITS     (AB),
    .KERNAL_SIZE      (KS),
    .NUMBER_OF_FILTERS(NF),
    .NUMBER_OF_UNITS  (NU)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .abort        (abort),
    .bus          (bus.slave),
    .busy         (busy),
    .load_done    (load_done),
    .start_to_next(start_to_next)
  );

  // Expected write for beat k of a load: unit k/PER, weights first then biases.
  function automatic wr_t exp_beat(input int k, input int data, input int c);
    wr_t r;
    int  u;
    int  w;
    u      = k / PER;
    w      = k % PER;
    r.cyc  = c;
    r.data = DW'(data);
    if (w < WM) begin
      r.wm   = NU'(1) << u;
      r.bm   = '0;
      r.addr = AB'(w);
    end else begin
      r.wm   = '0;
      r.bm   = NU'(1) << u;
      r.addr = AB'(w - WM);
    end
    return r;
  endfunction

  // Write monitor: every strobe must match the oldest expected write, in the
  // expected cycle; a strobe with nothing expected is an error.
  always @(negedge clk) begin
    wr_t e;
    if (start_to_next === 1'b1) stn_seen++;
    if (bus.wm_enable_write !== '0 || bus.bm_enable_write !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write cyc=%0d wm=%b bm=%b addr=%0d data=%0d",
                 cyc, bus.wm_enable_write, bus.bm_enable_write,
                 bus.riscv_address, bus.riscv_data);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e.cyc || bus.wm_enable_write !== e.wm || bus.bm_enable_write !== e.bm ||
            bus.riscv_address !== e.addr || bus.riscv_data !== e.data) begin
          failures++;
          $display("FAIL write got cyc=%0d wm=%b bm=%b addr=%0d data=%0d expected cyc=%0d wm=%b bm=%b addr=%0d data=%0d",
                   cyc, bus.wm_enable_write, bus.bm_enable_write, bus.riscv_address,
                   bus.riscv_data, e.cyc, e.wm, e.bm, e.addr, e.data);
        end
      end
    end
  end

  // Offers beats first..first+n-1 (data = base+k); optional idle cycle after each.
  task automatic drive_beats(input int first, input int n, input int base, input bit gap);
    for (int k = first; k < first + n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(base + k);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_ready_beat%0d got=%b expected=1", k, bus.in_ready);
      end
      exp_q.push_back(exp_beat(k, base + k, cyc + 1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL start busy=%b load_done=%b expected busy=1 load_done=0", busy, load_done);
    end
  endtask

  // Called right after the edge that accepted the final beat.
  task automatic expect_done(input int last_data, input int stn_before);
    checks++;
    if (start_to_next !== 1'b1 || load_done !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_entry stn=%b load_done=%b busy=%b in_ready=%b expected 1 1 0 0",
               start_to_next, load_done, busy, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (start_to_next !== 1'b0 || load_done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold stn=%b load_done=%b expected stn=0 load_done=1",
               start_to_next, load_done);
    end
    checks++;
    if (bus.riscv_data !== DW'(last_data) || bus.riscv_address !== AB'(BM - 1)) begin
      failures++;
      $display("FAIL bus_hold data=%0d addr=%0d expected data=%0d addr=%0d",
               bus.riscv_data, bus.riscv_address, last_data, BM - 1);
    end
    checks++;
    if (stn_seen !== stn_before + 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL stn_count got=%0d expected=%0d pending_writes=%0d expected=0",
               stn_seen - stn_before, 1, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    load_start   = 1'b1;
    abort        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b0 || start_to_next !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b load_done=%b stn=%b in_ready=%b expected all 0",
               busy, load_done, start_to_next, bus.in_ready);
    end
    checks++;
    if (bus.wm_enable_write !== '0 || bus.bm_enable_write !== '0 ||
        bus.riscv_data !== '0 || bus.riscv_address !== '0) begin
      failures++;
      $display("FAIL reset_bus wm=%b bm=%b data=%0d addr=%0d expected all 0",
               bus.wm_enable_write, bus.bm_enable_write, bus.riscv_data, bus.riscv_address);
    end
    load_start   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_nominal();
    int stn0;
    stn0 = stn_seen;
    start_load();
    drive_beats(0, TOTAL, 1, 1'b0);
    expect_done(TOTAL, stn0);
  endtask

  task automatic test_backpressure();
    int stn0;
    stn0 = stn_seen;
    start_load();
    drive_beats(0, TOTAL, 100, 1'b1);
    // Last beat was followed by a gap cycle, so DONE entry has already passed.
    checks++;
    if (load_done !== 1'b1 || start_to_next !== 1'b0 || stn_seen !== stn0 + 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL backpressure_done load_done=%b stn=%b pulses=%0d pending=%0d expected 1 0 1 0",
               load_done, start_to_next, stn_seen - stn0, exp_q.size());
    end
  endtask

  task automatic test_ignored_start();
    int stn0;
    stn0 = stn_seen;
    start_load();
    drive_beats(0, 3, 200, 1'b0);
    load_start = 1'b1;
    drive_beats(3, 1, 200, 1'b0);
    load_start = 1'b0;
    drive_beats(4, TOTAL - 4, 200, 1'b0);
    expect_done(200 + TOTAL - 1, stn0);
  endtask

  task automatic test_reload();
    int stn0;
    stn0 = stn_seen;
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL reload_pre load_done=%b expected 1", load_done);
    end
    start_load();
    drive_beats(0, TOTAL, 300, 1'b0);
    expect_done(300 + TOTAL - 1, stn0);
  endtask

  task automatic test_abort();
    int stn0;
    stn0 = stn_seen;
    start_load();
    drive_beats(0, 4, 400, 1'b0);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(777);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready got=%b expected=0", bus.in_ready);
    end
    @(posedge clk); #1;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b load_done=%b expected 0 0", busy, load_done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stn_seen !== stn0 || busy !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL abort_quiet pulses=%0d busy=%b pending=%0d expected 0 0 0",
               stn_seen - stn0, busy, exp_q.size());
    end
    // Abort wins over a simultaneous load_start.
    abort      = 1'b1;
    load_start = 1'b1;
    @(posedge clk); #1;
    abort      = 1'b0;
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_priority busy=%b expected 0", busy);
    end
    start_load();
    drive_beats(0, TOTAL, 500, 1'b0);
    expect_done(500 + TOTAL - 1, stn0);
    // Abort from DONE drops load_done.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_done load_done=%b busy=%b expected 0 0", load_done, busy);
    end
  endtask

  task automatic test_reset_midload();
    int stn0;
    stn0 = stn_seen;
    start_load();
    drive_beats(0, 10, 600, 1'b0);
    reset        = 1'b0;
    load_start   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(999);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || load_done !== 1'b0 || start_to_next !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.wm_enable_write !== '0 || bus.bm_enable_write !== '0 ||
        bus.riscv_data !== '0 || bus.riscv_address !== '0) begin
      failures++;
      $display("FAIL midload_reset busy=%b done=%b stn=%b rdy=%b wm=%b bm=%b data=%0d addr=%0d expected all 0",
               busy, load_done, start_to_next, bus.in_ready, bus.wm_enable_write,
               bus.bm_enable_write, bus.riscv_data, bus.riscv_address);
    end
    reset        = 1'b1;
    load_start   = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL midload_idle busy=%b pending=%0d expected 0 0", busy, exp_q.size());
    end
    start_load();
    drive_beats(0, TOTAL, 700, 1'b0);
    expect_done(700 + TOTAL - 1, stn0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ignored_start();
    test_reload();
    test_abort();
    test_reset_midload();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL final_pending got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
